// File: rtl/lsq_issue_arbiter.sv
// rtl/lsq_issue_arbiter.sv - load/store issue arbiter with bounded store starvation and fence drain
// Loads win by default; one subunit at a time keeps load responses in order.
module lsq_issue_arbiter #(
   parameter int NUM_SUBUNITS    = 3,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 8,
   parameter int SUB_W           = (NUM_SUBUNITS > 1) ? $clog2(NUM_SUBUNITS) : 1,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   input  logic [SUB_W-1:0]        load_subunit,
   input  logic                    store_valid,
   input  logic [SUB_W-1:0]        store_subunit,
   input  logic [NUM_SUBUNITS-1:0] subunit_ready,
   input  logic                    load_complete,
   input  logic                    drain_req,
   input  logic                    sq_empty,
   output logic                    load_pop,
   output logic                    store_pop,
   output logic                    issue_store,
   output logic [SUB_W-1:0]        issue_subunit,
   output logic [CNT_W-1:0]        outstanding_loads,
   output logic                    drained
);

   localparam int STV_W = $clog2(STARVE_LIMIT);

   localparam logic [1:0] ST_NORMAL = 2'd0;
   localparam logic [1:0] ST_FORCE  = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [STV_W-1:0] STV_TOP = STV_W'(STARVE_LIMIT - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [STV_W-1:0] starve_q, starve_d;
   logic [SUB_W-1:0] last_sub_q, last_sub_d;

   logic load_sub_rdy;
   logic store_sub_rdy;
   logic load_ok;
   logic store_ok;
   logic complete_ok;
   logic store_blocked;

   // Out-of-range subunit codes select no ready bit and therefore never issue.
   always_comb begin
      load_sub_rdy  = 1'b0;
      store_sub_rdy = 1'b0;
      for (int i = 0; i < NUM_SUBUNITS; i++) begin
         if (load_subunit == SUB_W'(i)) load_sub_rdy = subunit_ready[i];
         if (store_subunit == SUB_W'(i)) store_sub_rdy = subunit_ready[i];
      end
   end

   assign load_ok = rst & load_valid & load_sub_rdy
                  & (outstanding_q < MAX_CNT)
                  & ((outstanding_q == '0) | (load_subunit == last_sub_q))
                  & (state_q == ST_NORMAL);

   assign store_ok      = rst & store_valid & store_sub_rdy;
   assign load_pop      = load_ok;
   assign store_pop     = store_ok & ~load_ok;
   assign issue_store   = store_pop;
   assign issue_subunit = store_pop ? store_subunit : load_subunit;

   assign complete_ok   = load_complete & (outstanding_q != '0);
   assign store_blocked = store_valid & ~store_pop;

   always_comb begin
      outstanding_d = outstanding_q;
      if (load_pop && !complete_ok) begin
         outstanding_d = outstanding_q + 1'b1;
      end else if (!load_pop && complete_ok) begin
         outstanding_d = outstanding_q - 1'b1;
      end
   end

   assign last_sub_d = load_pop ? load_subunit : last_sub_q;

   always_comb begin
      state_d  = state_q;
      starve_d = '0;
      case (state_q)
         ST_NORMAL: begin
            if (store_blocked) starve_d = starve_q + 1'b1;
            if (drain_req) begin
               state_d  = ST_DRAIN;
               starve_d = '0;
            end else if (store_blocked && (starve_q == STV_TOP)) begin
               state_d  = ST_FORCE;
               starve_d = '0;
            end
         end
         ST_FORCE: begin
            if (store_pop) begin
               state_d = drain_req ? ST_DRAIN : ST_NORMAL;
            end else if (!store_valid) begin
               state_d = ST_NORMAL;
            end
         end
         ST_DRAIN: begin
            if (!drain_req) state_d = ST_NORMAL;
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_NORMAL;
         outstanding_q <= '0;
         starve_q      <= '0;
         last_sub_q    <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         starve_q      <= starve_d;
         last_sub_q    <= last_sub_d;
      end
   end

   assign outstanding_loads = outstanding_q;
   assign drained = (state_q == ST_DRAIN) & sq_empty & (outstanding_q == '0);

   always @(posedge clk) begin
      if (rst) begin
         assert (!(load_complete && (outstanding_q == '0)))
            else $warning("lsq_issue_arbiter: load_complete with no outstanding loads ignored");
      end
   end

endmodule
